// File: rtl/tpu_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tpu_stream_sequencer
// Brief    : Runs one matrix job on the systolic TPU: weight load, ifmap
//            streaming with bubbles, pipeline drain and psum row tagging.
// Revision : 1.0 - initial release
// ============================================================================
module tpu_stream_sequencer #(
    parameter int ROWS     = 4,
    parameter int COLS     = 6,
    parameter int WT_W     = 384,
    parameter int CNT_W    = 8,
    parameter int LOAD_CYC = 1,
    parameter int PIPE_LAT = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   vec_count,
    input  logic               wt_valid,
    input  logic [WT_W-1:0]    wt_data,
    output logic               wt_ready,
    input  logic               src_valid,
    input  logic [ROWS*16-1:0] src_data,
    output logic               src_ready,
    output logic               tpu_load_en,
    output logic [WT_W-1:0]    tpu_weights,
    output logic [ROWS*16-1:0] tpu_ifmap,
    input  logic [COLS*16-1:0] tpu_psum,
    output logic               out_valid,
    output logic [COLS*16-1:0] out_data,
    output logic               busy,
    output logic               done
);
    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_load   = 3'd1;
    localparam logic [2:0] c_stream = 3'd2;
    localparam logic [2:0] c_drain  = 3'd3;
    localparam logic [2:0] c_done   = 3'd4;

    localparam int c_load_w  = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
    localparam int c_drain_w = $clog2(PIPE_LAT + 2);
    localparam logic [c_load_w-1:0]  c_load_last  = c_load_w'(LOAD_CYC - 1);
    // Drain covers the ifmap register, the array latency and the out register,
    // so the final out_valid lands in the cycle just before done.
    localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(PIPE_LAT + 1);

    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     r_acc;
    logic                 r_wt_got;
    logic [c_load_w-1:0]  r_load_cnt;
    logic [c_drain_w-1:0] r_drain_cnt;
    logic                 r_tag;
    logic [PIPE_LAT-1:0]  r_tag_pipe;
    logic [CNT_W-1:0]     w_acc_next;

    assign w_acc_next = r_acc + CNT_W'(1);
    assign wt_ready   = (r_state == c_load) && !r_wt_got;
    assign src_ready  = (r_state == c_stream);
    assign busy       = (r_state != c_idle);
    assign done       = (r_state == c_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_count     <= '0;
            r_acc       <= '0;
            r_wt_got    <= 1'b0;
            r_load_cnt  <= '0;
            r_drain_cnt <= '0;
            r_tag       <= 1'b0;
            tpu_load_en <= 1'b0;
            tpu_weights <= '0;
            tpu_ifmap   <= '0;
        end else begin
            tpu_ifmap <= '0;
            r_tag     <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        if (vec_count != '0) begin
                            r_count  <= vec_count;
                            r_acc    <= '0;
                            r_wt_got <= 1'b0;
                            r_state  <= c_load;
                        end else begin
                            r_state <= c_done;
                        end
                    end
                end
                c_load: begin
                    if (!r_wt_got) begin
                        if (wt_valid) begin
                            tpu_weights <= wt_data;
                            r_wt_got    <= 1'b1;
                            tpu_load_en <= 1'b1;
                            r_load_cnt  <= '0;
                        end
                    end else if (r_load_cnt == c_load_last) begin
                        tpu_load_en <= 1'b0;
                        r_state     <= c_stream;
                    end else begin
                        r_load_cnt <= r_load_cnt + c_load_w'(1);
                    end
                end
                c_stream: begin
                    if (src_valid) begin
                        tpu_ifmap <= src_data;
                        r_tag     <= 1'b1;
                        r_acc     <= w_acc_next;
                        if (w_acc_next == r_count) begin
                            r_drain_cnt <= '0;
                            r_state     <= c_drain;
                        end
                    end
                end
                c_drain: begin
                    if (r_drain_cnt == c_drain_last) begin
                        r_state <= c_done;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + c_drain_w'(1);
                    end
                end
                c_done:  r_state <= c_idle;
                default: r_state <= c_idle;
            endcase
        end
    end

    // Tag rides alongside each vector through the array latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_pipe <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            r_tag_pipe[0] <= r_tag;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_tag_pipe[i] <= r_tag_pipe[i-1];
            end
            out_valid <= r_tag_pipe[PIPE_LAT-1];
            if (r_tag_pipe[PIPE_LAT-1]) begin
                out_data <= tpu_psum;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tpu_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_stream_sequencer
// Brief    : Scoreboard bench for tpu_stream_sequencer with a 4x6 array stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_stream_sequencer;
    localparam int ROWS     = 4;
    localparam int COLS     = 6;
    localparam int WT_W     = 384;
    localparam int CNT_W    = 8;
    localparam int LOAD_CYC = 1;
    localparam int PIPE_LAT = 10;
    localparam int IF_W     = ROWS * 16;
    localparam int PS_W     = COLS * 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  vec_count = '0;
    logic              wt_valid = 1'b0;
    logic [WT_W-1:0]   wt_data = '0;
    logic              wt_ready;
    logic              src_valid = 1'b0;
    logic [IF_W-1:0]   src_data = '0;
    logic              src_ready;
    logic              tpu_load_en;
    logic [WT_W-1:0]   tpu_weights;
    logic [IF_W-1:0]   tpu_ifmap;
    logic [PS_W-1:0]   tpu_psum;
    logic              out_valid;
    logic [PS_W-1:0]   out_data;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    tpu_stream_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .WT_W(WT_W), .CNT_W(CNT_W),
        .LOAD_CYC(LOAD_CYC), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vec_count(vec_count),
        .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .tpu_load_en(tpu_load_en), .tpu_weights(tpu_weights), .tpu_ifmap(tpu_ifmap),
        .tpu_psum(tpu_psum), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .done(done)
    );

    // Golden 4x6 product: psum[c] = sum_r ifmap[r] * w[r][c], 16-bit wrap.
    function automatic logic [PS_W-1:0] mm(input logic [IF_W-1:0] v, input logic [WT_W-1:0] w);
        logic [PS_W-1:0] res;
        logic [15:0]     acc;
        logic [31:0]     p;
        res = '0;
        for (int c = 0; c < COLS; c++) begin
            acc = '0;
            for (int r = 0; r < ROWS; r++) begin
                p   = v[r*16 +: 16] * w[(r*COLS+c)*16 +: 16];
                acc = acc + p[15:0];
            end
            res[c*16 +: 16] = acc;
        end
        return res;
    endfunction

    function automatic logic [WT_W-1:0] rand_w();
        logic [WT_W-1:0] r;
        for (int i = 0; i < WT_W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Array stand-in: weights latch on load_en, psum appears PIPE_LAT cycles after ifmap.
    logic [WT_W-1:0] arr_w = '0;
    logic [PS_W-1:0] arr_pipe [PIPE_LAT];
    always @(posedge clk) begin
        if (tpu_load_en) arr_w <= tpu_weights;
        arr_pipe[0] <= mm(tpu_ifmap, arr_w);
        for (int i = 1; i < PIPE_LAT; i++) arr_pipe[i] <= arr_pipe[i-1];
    end
    assign tpu_psum = arr_pipe[PIPE_LAT-1];

    typedef struct {
        logic [PS_W-1:0] data;
        int              cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int load_total = 0;
    int done_total = 0;
    int ov_total = 0;
    int last_ov_cyc = -1;
    int jobs_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [WT_W-1:0] act, input logic [WT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a psum row is presented.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (tpu_load_en) load_total++;
            if (out_valid) begin
                ov_total++;
                last_ov_cyc = cyc;
                if (sb.size() == 0) begin
                    check_int("unexpected_out_valid", int'(out_valid), 0);
                end else begin
                    mon_e = sb.pop_front();
                    check_vec("psum_row", WT_W'(out_data), WT_W'(mon_e.data));
                    check_int("psum_latency", cyc, mon_e.cyc);
                end
            end
            if (done) begin
                done_total++;
                check_int("rows_pending_at_done", sb.size(), 0);
            end
        end
    end

    // mode: 0 src_valid tied high, 1 fixed stall pattern, 2 random stalls
    task automatic run_job(input int n, input int wt_delay, input int mode,
                           input logic [WT_W-1:0] w, input bit repulse, input bit b2b);
        int  ld0, dn0, ov0, acc, pidx, t, h_cyc;
        bit  seen_rdy;
        bit  pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        start     = 1'b1;
        vec_count = CNT_W'(n);
        wt_valid  = (wt_delay == 0);
        wt_data   = w;
        ld0 = load_total; dn0 = done_total; ov0 = ov_total;
        @(negedge clk);
        start     = 1'b0;
        vec_count = CNT_W'($urandom);
        if (n == 0) begin
            check_int("zero_job_done_next_cycle", int'(done), 1);
            wt_valid = 1'b0;
            repeat (4) @(negedge clk);
            check_int("zero_job_load_en", load_total - ld0, 0);
            check_int("zero_job_rows", ov_total - ov0, 0);
            check_int("zero_job_done_count", done_total - dn0, 1);
            jobs_done++;
            return;
        end
        check_int("wt_ready_in_load", int'(wt_ready), 1);
        t = 1;
        h_cyc = -100;
        forever begin
            wt_valid = (t >= wt_delay);
            start    = repulse && (t == 2);
            if (wt_valid && wt_ready) begin
                h_cyc = cyc;
                break;
            end
            if (t > 100) begin
                check_int("wt_handshake_timeout", int'(wt_ready), 1);
                break;
            end
            check_int("src_ready_before_weights", int'(src_ready), 0);
            t++;
            @(negedge clk);
        end
        @(negedge clk);
        wt_valid = 1'b0;
        start    = 1'b0;
        check_vec("tpu_weights", tpu_weights, w);
        check_int("wt_ready_after_handshake", int'(wt_ready), 0);
        check_int("load_en_after_handshake", int'(tpu_load_en), 1);
        acc = 0; pidx = 0; t = 0; seen_rdy = 1'b0;
        while (acc < n) begin
            if (src_ready && !seen_rdy) begin
                seen_rdy = 1'b1;
                check_int("first_src_ready_cycle", cyc, h_cyc + LOAD_CYC + 1);
            end
            case (mode)
                0:       src_valid = 1'b1;
                1:       src_valid = pat[pidx % 7];
                default: src_valid = ($urandom_range(0, 3) != 0);
            endcase
            src_data = {$urandom, $urandom};
            start    = repulse && (t == 3);
            if (start) vec_count = CNT_W'(9);
            if (src_ready) pidx++;
            if (src_valid && src_ready) begin
                sb.push_back('{data: mm(src_data, w), cyc: cyc + PIPE_LAT + 2});
                acc++;
            end
            t++;
            if (t > n * 8 + 200) begin
                check_int("stream_timeout_accepted", acc, n);
                break;
            end
            @(negedge clk);
        end
        src_valid = 1'b0;
        start     = 1'b0;
        check_int("src_ready_after_last", int'(src_ready), 0);
        t = 0;
        while (!done && t < 64) begin
            @(negedge clk);
            t++;
        end
        check_int("done_seen", int'(done), 1);
        check_int("done_follows_last_row", cyc, last_ov_cyc + 1);
        check_int("rows_delivered", ov_total - ov0, n);
        check_int("load_en_cycles", load_total - ld0, LOAD_CYC);
        jobs_done++;
        if (!b2b) begin
            @(negedge clk);
            check_int("busy_after_done", int'(busy), 0);
            repeat (2) @(negedge clk);
            check_int("done_pulse_count", done_total - dn0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dn0, ov0;
        repeat (3) @(negedge clk);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_load_en", int'(tpu_load_en), 0);
        check_int("reset_ready", int'({wt_ready, src_ready}), 0);
        check_vec("reset_weights", tpu_weights, '0);
        check_vec("reset_ifmap", WT_W'(tpu_ifmap), '0);
        check_vec("reset_out_data", WT_W'(out_data), '0);
        rst = 1'b0;

        run_job(3, 0, 0, rand_w(), 1'b0, 1'b0);
        run_job(4, 0, 1, rand_w(), 1'b0, 1'b0);
        run_job(0, 0, 0, rand_w(), 1'b0, 1'b0);
        run_job(5, 5, 0, rand_w(), 1'b1, 1'b0);
        run_job(255, 0, 2, rand_w(), 1'b0, 1'b1);
        run_job(6, 0, 0, rand_w(), 1'b0, 1'b0);

        // Abort mid-stream.
        @(negedge clk);
        start = 1'b1; vec_count = CNT_W'(20); wt_valid = 1'b1; wt_data = rand_w();
        @(negedge clk);
        start = 1'b0; src_valid = 1'b1;
        repeat (8) @(negedge clk);
        check_int("abort_in_stream", int'(src_ready), 1);
        rst = 1'b1;
        #1;
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_flags", int'({done, out_valid, tpu_load_en, wt_ready, src_ready}), 0);
        check_vec("abort_weights", tpu_weights, '0);
        check_vec("abort_ifmap", WT_W'(tpu_ifmap), '0);
        @(negedge clk);
        src_valid = 1'b0; wt_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        dn0 = done_total; ov0 = ov_total;
        repeat (30) @(negedge clk);
        check_int("abort_no_done", done_total - dn0, 0);
        check_int("abort_no_rows", ov_total - ov0, 0);

        for (int j = 0; j < 4; j++) begin
            run_job($urandom_range(1, 20), $urandom_range(0, 4), $urandom_range(0, 2),
                    rand_w(), 1'b0, 1'b0);
        end

        check_int("total_done_pulses", done_total, jobs_done);
        check_int("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
